// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Requester ids double as mux select codes; 2'b11 is never produced.
package mux_arb_pkg;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   localparam logic [1:0] SRC_A = 2'd0;
   localparam logic [1:0] SRC_B = 2'd1;
   localparam logic [1:0] SRC_C = 2'd2;
   localparam int         N_REQ = 3;

   // Successor in the 0 -> 1 -> 2 -> 0 rotation.
   function automatic logic [1:0] next_src(input logic [1:0] s);
      return (s == SRC_C) ? SRC_A : s + 2'd1;
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters: the winner is the
// first set req bit at or after ptr, scanning 0 -> 1 -> 2 -> 0.
module rr_pick3
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       ptr,
   output logic [1:0]       win,
   output logic             any
);

   logic [3:0] req_pad;
   logic [1:0] ptr1;
   logic [1:0] ptr2;

   // Padding lets a 2-bit index address the vector without running off the end.
   assign req_pad = {1'b0, req};
   assign ptr1    = next_src(ptr);
   assign ptr2    = next_src(ptr1);
   assign any     = |req;

   always_comb begin
      // NOTE: win gets a value before any branch, so no path leaves it unassigned (no latch).
      win = ptr;
      if (req_pad[ptr])
         win = ptr;
      else if (req_pad[ptr1])
         win = ptr1;
      else if (req_pad[ptr2])
         win = ptr2;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 3:1 data mux between requesters a/b/c, with a
// valid/ready result register. Optional grant counters under MUX_ARB_STATS_EN.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int OUT_W  = 6,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   output logic [N_REQ-1:0]  gnt,
   output logic [1:0]        sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
`ifdef MUX_ARB_STATS_EN
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt_a,
   output logic [CNT_W-1:0]  cnt_b,
   output logic [CNT_W-1:0]  cnt_c,
`endif
   output logic [1:0]        out_src
);

   arb_state_t        state, state_nxt;
   logic [1:0]        ptr;
   logic [1:0]        win;
   logic              any;
   logic              capture;
   logic [DATA_W-1:0] mux_data;

   rr_pick3 u_pick (
      .req (req),
      .ptr (ptr),
      .win (win),
      .any (any)
   );

   always_comb begin
      case (win)
         SRC_A:   mux_data = a;
         SRC_B:   mux_data = b;
         SRC_C:   mux_data = c;
         default: mux_data = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: if (any) begin
            capture   = 1'b1;
            state_nxt = BUSY;
         end
         BUSY: if (out_ready) begin
            // A handshake with a request pending refills in the same edge.
            if (any) capture   = 1'b1;
            else     state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt      <= '0;
         ptr      <= SRC_A;
         out_src  <= SRC_A;
         out_data <= '0;
      end else begin
         gnt <= '0;
         if (capture) begin
            gnt      <= N_REQ'(1) << win;
            ptr      <= next_src(win);
            out_src  <= win;
            out_data <= OUT_W'(mux_data);
         end
      end
   end

   // Reset clears the state flop asynchronously, so valid drops without waiting for clk.
   assign out_valid = (state == BUSY);
   assign sel       = out_src;

`ifdef MUX_ARB_STATS_EN
   logic [N_REQ-1:0][CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (cnt_clr)
               cnt[i] <= '0;
            else if (gnt[i] && (cnt[i] != '1))
               cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   assign cnt_a = cnt[0];
   assign cnt_b = cnt[1];
   assign cnt_c = cnt[2];
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a behavioural arbitration model pushes
// expected results at each capture; they are popped on each output handshake.
module tb_mux_rr_arbiter;

   localparam int DATA_W = 4;
   localparam int OUT_W  = 6;
   localparam int CNT_W  = 8;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic [1:0]       src;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [2:0]        req = '0;
   logic [DATA_W-1:0] a = '0, b = '0, c = '0;
   logic              out_ready = 1'b0;
   logic [2:0]        gnt;
   logic [1:0]        sel;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic [1:0]        out_src;
`ifdef MUX_ARB_STATS_EN
   logic              cnt_clr = 1'b0;
   logic [CNT_W-1:0]  cnt_a, cnt_b, cnt_c;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];

   // Reference model state
   logic       m_busy = 1'b0;
   logic [1:0] m_ptr  = 2'd0;
   logic [1:0] m_src  = 2'd0;
   logic [2:0] m_gnt  = 3'd0;

   mux_rr_arbiter #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a         (a),
      .b         (b),
      .c         (c),
      .gnt       (gnt),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef MUX_ARB_STATS_EN
      .cnt_clr   (cnt_clr),
      .cnt_a     (cnt_a),
      .cnt_b     (cnt_b),
      .cnt_c     (cnt_c),
`endif
      .out_src   (out_src)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] req_data(input int i);
      return (i == 0) ? a : (i == 1) ? b : c;
   endfunction

   // Behavioural arbiter: decides captures from the inputs seen at each edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0;
         m_ptr  = 2'd0;
         m_src  = 2'd0;
         m_gnt  = 3'd0;
         sb_q.delete();
      end else begin
         logic hs;
         logic found;
         int   w;
         hs    = m_busy && out_ready;
         found = 1'b0;
         w     = 0;
         m_gnt = 3'd0;
         if (!m_busy || hs) begin
            for (int k = 0; k < 3; k++) begin
               int i;
               i = (int'(m_ptr) + k) % 3;
               if (!found && req[i]) begin
                  found = 1'b1;
                  w     = i;
               end
            end
         end
         if (found) begin
            exp_t e;
            e.data = {2'b00, req_data(w)};
            e.src  = 2'(w);
            sb_q.push_back(e);
            m_gnt  = 3'(1 << w);
            m_src  = 2'(w);
            m_ptr  = 2'((w + 1) % 3);
            m_busy = 1'b1;
         end else if (hs) begin
            m_busy = 1'b0;
         end
      end
   end

   // Mid-cycle checker: control outputs every cycle, data popped on handshake.
   always @(negedge clk) begin
      if (!rst) begin
         check("out_valid", 32'(out_valid), 32'(m_busy));
         check("gnt", 32'(gnt), 32'(m_gnt));
         check("sel", 32'(sel), 32'(m_src));
         if (out_valid && sb_q.size() > 0)
            check("hold_data", 32'(out_data), 32'(sb_q[0].data));
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_empty", 32'(1), 32'(0));
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("xfer_data", 32'(out_data), 32'(e.data));
               check("xfer_src", 32'(out_src), 32'(e.src));
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [OUT_W-1:0] seq_data [6];
   logic [2:0]       seq_gnt  [6];

   initial begin
      // 1: reset, then idle with no requests
      #1 rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(5);
      check("rst_valid", 32'(out_valid), 32'(0));
      check("rst_gnt", 32'(gnt), 32'(0));
      check("rst_sel", 32'(sel), 32'(0));
      check("rst_data", 32'(out_data), 32'(0));
      check("rst_src", 32'(out_src), 32'(0));

      // 2: single request from b
      req = 3'b010; b = 4'hA; out_ready = 1'b1;
      step(1);
      check("t2_gnt", 32'(gnt), 32'(3'b010));
      check("t2_data", 32'(out_data), 32'(6'h0A));
      check("t2_src", 32'(out_src), 32'(1));
      check("t2_sel", 32'(sel), 32'(1));
      req = 3'b000;
      step(1);
      check("t2_idle", 32'(out_valid), 32'(0));
      check("t2_keep", 32'(out_data), 32'(6'h0A));

      // 3: all requesting, back-to-back rotation from a fresh pointer
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      a = 4'd1; b = 4'd2; c = 4'd3; req = 3'b111; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         seq_data[i] = out_data;
         seq_gnt[i]  = gnt;
      end
      for (int i = 0; i < 6; i++) begin
         check("t3_data", 32'(seq_data[i]), 32'((i % 3) + 1));
         check("t3_gnt", 32'(seq_gnt[i]), 32'(1 << (i % 3)));
      end
      req = 3'b000;
      step(2);

      // 4: stalled consumer holds the result; grant pulses once
      req = 3'b001; a = 4'h5; out_ready = 1'b0;
      step(1);
      check("t4_gnt", 32'(gnt), 32'(3'b001));
      req = 3'b000;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("t4_hold_gnt", 32'(gnt), 32'(0));
         check("t4_hold_valid", 32'(out_valid), 32'(1));
         check("t4_hold_data", 32'(out_data), 32'(6'h05));
      end
      out_ready = 1'b1;
      step(1);
      check("t4_done", 32'(out_valid), 32'(0));

      // 5: asynchronous reset while busy and stalled
      req = 3'b100; c = 4'h7; out_ready = 1'b0;
      step(1);
      check("t5_busy", 32'(out_valid), 32'(1));
      req = 3'b000;
      #2 rst = 1'b1;
      #1;
      check("t5_async_valid", 32'(out_valid), 32'(0));
      check("t5_async_data", 32'(out_data), 32'(0));
      check("t5_async_gnt", 32'(gnt), 32'(0));
      step(1);
      rst = 1'b0;
      req = 3'b111; out_ready = 1'b1;
      step(1);
      check("t5_ptr0_gnt", 32'(gnt), 32'(3'b001));
      req = 3'b000;
      step(2);

`ifdef MUX_ARB_STATS_EN
      // 6: saturation and clear-over-increment
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      req = 3'b001; out_ready = 1'b1;
      step(300);
      check("t6_sat", 32'(cnt_a), 32'(255));
      check("t6_gnt_live", 32'(gnt), 32'(3'b001));
      cnt_clr = 1'b1;
      step(1);
      cnt_clr = 1'b0;
      check("t6_clr", 32'(cnt_a), 32'(0));
      check("t6_cnt_b", 32'(cnt_b), 32'(0));
      req = 3'b000;
      step(2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
